// File: rtl/proc_ctrl_pkg.sv
// Shared definitions for the processor control path: state encoding, timeout
// defaults and the registered strobe bundle driven by the fetch/execute sequencer.
package proc_ctrl_pkg;

  localparam int unsigned TIMEOUT_W_DEF   = 4;
  localparam int unsigned MEM_TIMEOUT_DEF = 15;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_FETCH_ADDR = 3'd1,
    ST_FETCH_WAIT = 3'd2,
    ST_LOAD_IR    = 3'd3,
    ST_EXEC       = 3'd4,
    ST_BRANCH     = 3'd5,
    ST_HALT       = 3'd6,
    ST_ERROR      = 3'd7
  } state_e;

  typedef struct packed {
    logic mar_we;
    logic mem_rd_req;
    logic ir_we;
    logic pc_inc;
    logic pc_we;
    logic exec_start;
    logic busy;
    logic halted;
    logic err;
  } ctrl_out_t;

  // Per-state strobe decode; exec_start needs history and is added by the caller.
  function automatic ctrl_out_t decode_state(input state_e s);
    ctrl_out_t o;
    o = '0;
    case (s)
      ST_FETCH_ADDR: begin o.mar_we = 1'b1;     o.busy = 1'b1; end
      ST_FETCH_WAIT: begin o.mem_rd_req = 1'b1; o.busy = 1'b1; end
      ST_LOAD_IR:    begin o.ir_we = 1'b1; o.pc_inc = 1'b1; o.busy = 1'b1; end
      ST_EXEC:       o.busy   = 1'b1;
      ST_BRANCH:     begin o.pc_we = 1'b1;      o.busy = 1'b1; end
      ST_HALT:       o.halted = 1'b1;
      ST_ERROR:      o.err    = 1'b1;
      default:       o = '0;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/wait_timer.sv
// Memory-wait cycle counter: cleared before each fetch, advanced on every
// ack-less wait cycle, flags the last permitted wait cycle.
module wait_timer #(
  parameter int unsigned W  = 4,
  parameter int unsigned TC = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc_c
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + W'(1);
    end
  end

  // Count holds the number of completed wait cycles, so TC-1 marks the TC-th one.
  assign o_tc_c = (r_count == W'(TC - 1));

endmodule

// File: rtl/fetch_exec_sequencer.sv
// Fetch/execute control FSM: sequences MAR, memory read, IR/PC strobes and the
// execute-unit handshake. All outputs are registered from the next state.
module fetch_exec_sequencer
  import proc_ctrl_pkg::*;
#(
  parameter int unsigned DATA_LEN    = 16,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned TIMEOUT_W   = TIMEOUT_W_DEF,
  parameter int unsigned MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             halt_req,
  input  logic             mem_rd_ack,
  input  logic             exec_done,
  input  logic             branch_taken,
  input  logic             halt_instr,
  output logic             mar_we,
  output logic             mem_rd_req,
  output logic             ir_we,
  output logic             pc_inc,
  output logic             pc_we,
  output logic             exec_start,
  output logic             busy,
  output logic             halted,
  output logic             err,
  output logic [CNT_W-1:0] instr_count
);

  if (DATA_LEN == 0 || MEM_TIMEOUT == 0 ||
      MEM_TIMEOUT > (32'd1 << TIMEOUT_W) - 32'd1) begin : g_param_check
    $error("fetch_exec_sequencer: MEM_TIMEOUT must be 1..2**TIMEOUT_W-1");
  end

  state_e           r_state;
  state_e           w_state_nxt;
  ctrl_out_t        r_out;
  ctrl_out_t        w_out_nxt;
  logic [CNT_W-1:0] r_instr_count;
  logic             w_tmr_tc;

  wait_timer #(
    .W  (TIMEOUT_W),
    .TC (MEM_TIMEOUT)
  ) u_wait_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_clr  (r_state == ST_FETCH_ADDR),
    .i_en   ((r_state == ST_FETCH_WAIT) && !mem_rd_ack),
    .o_tc_c (w_tmr_tc)
  );

  // Next state, then registered outputs decoded from that next state.
  always_comb begin
    w_state_nxt = r_state;
    w_out_nxt   = '0;
    case (r_state)
      ST_IDLE:       if (start && !halt_req) w_state_nxt = ST_FETCH_ADDR;
      ST_FETCH_ADDR: w_state_nxt = ST_FETCH_WAIT;
      ST_FETCH_WAIT: begin
        if (mem_rd_ack)    w_state_nxt = ST_LOAD_IR;
        else if (w_tmr_tc) w_state_nxt = ST_ERROR;
      end
      ST_LOAD_IR:    w_state_nxt = ST_EXEC;
      ST_EXEC: begin
        if (exec_done) begin
          if (halt_instr)        w_state_nxt = ST_HALT;
          else if (branch_taken) w_state_nxt = ST_BRANCH;
          else if (halt_req)     w_state_nxt = ST_IDLE;
          else                   w_state_nxt = ST_FETCH_ADDR;
        end
      end
      ST_BRANCH:     w_state_nxt = halt_req ? ST_IDLE : ST_FETCH_ADDR;
      ST_HALT:       w_state_nxt = ST_HALT;
      ST_ERROR:      w_state_nxt = ST_ERROR;
      default:       w_state_nxt = ST_IDLE;
    endcase
    w_out_nxt            = decode_state(w_state_nxt);
    w_out_nxt.exec_start = (w_state_nxt == ST_EXEC) && (r_state != ST_EXEC);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_out   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_out   <= w_out_nxt;
    end
  end

  // Retired count advances as the IR load completes; wraps naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_instr_count <= '0;
    end else if (r_state == ST_LOAD_IR) begin
      r_instr_count <= r_instr_count + CNT_W'(1);
    end
  end

  assign mar_we      = r_out.mar_we;
  assign mem_rd_req  = r_out.mem_rd_req;
  assign ir_we       = r_out.ir_we;
  assign pc_inc      = r_out.pc_inc;
  assign pc_we       = r_out.pc_we;
  assign exec_start  = r_out.exec_start;
  assign busy        = r_out.busy;
  assign halted      = r_out.halted;
  assign err         = r_out.err;
  assign instr_count = r_instr_count;

endmodule
